// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    IDLE = 2'd2
  } state_t;

  localparam logic [31:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } buf_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction memory port: req/gnt address phase, in-order rvalid data phase.
interface ifetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_gnt, input imem_rvalid, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_gnt, output imem_rvalid, output imem_rdata);
endinterface

// File: rtl/ifetch_buf.sv
// Synchronous FIFO holding fetched {instr, pc} pairs; flush empties it in one cycle.
module ifetch_buf
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  buf_entry_t    wdata,
  output buf_entry_t    rdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  buf_entry_t        mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  // storage array; cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push && !flush) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // pointers and occupancy; flush has priority over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == '0);

endmodule

// File: rtl/ifetch_unit_chk.sv
// Protocol checker: a response with nothing outstanding is illegal once fetching has started.
module ifetch_unit_chk (
  input logic clk,
  input logic rst_n,
  input logic gnt,
  input logic rvalid,
  input logic no_outst
);

  logic armed_r;

  // responses before the first grant after reset are leftovers of pre-reset traffic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed_r <= 1'b0;
    else        armed_r <= armed_r | gnt;
  end

  stray_rsp_a: assert property (@(posedge clk) disable iff (!rst_n)
                                !(armed_r && rvalid && no_outst))
    else $error("imem_rvalid with no outstanding request");

endmodule

// File: rtl/ifetch_unit.sv
// Fetch unit: PC, redirect handling, imem request/response tracking and decode buffer.
// Optional performance counters enabled by defining IFETCH_PERF_CNT_EN.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_pc,
  ifetch_if.master    imem,
  output logic        instr_vld,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_rdy
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_dropped
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  state_t        state_r, state_nxt_s;
  logic          issue_en_s;
  logic [31:0]   fetch_pc_r, resp_pc_r, tgt_s;
  logic [CW-1:0] outst_r, drop_r, outst_nxt_s, count_s;
  logic          req_s, gnt_s, rsp_s, discard_s, push_s, pop_s, empty_s;
  buf_entry_t    push_entry_s, head_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= BOOT;
    else        state_r <= state_nxt_s;
  end

  // FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      BOOT:    if (fetch_en) state_nxt_s = RUN;  else state_nxt_s = BOOT;
      RUN:     if (fetch_en) state_nxt_s = RUN;  else state_nxt_s = IDLE;
      IDLE:    if (fetch_en) state_nxt_s = RUN;  else state_nxt_s = IDLE;
      default: state_nxt_s = BOOT;
    endcase
  end

  // FSM outputs
  always_comb begin
    issue_en_s = (state_r == RUN);
  end

  // credit check counts both in-flight words and buffered words so a response always has a slot
  assign req_s = issue_en_s && !redirect_vld
                 && (({1'b0, outst_r} + {1'b0, count_s}) < (CW + 1)'(BUF_DEPTH))
                 && (outst_r < CW'(MAX_OUTST));
  assign gnt_s       = req_s & imem.imem_gnt;
  assign rsp_s       = imem.imem_rvalid & (outst_r != '0);
  assign discard_s   = rsp_s & (redirect_vld | (drop_r != '0));
  assign push_s      = rsp_s & !discard_s;
  assign pop_s       = instr_vld & instr_rdy & !redirect_vld;
  assign outst_nxt_s = outst_r + CW'(gnt_s) - CW'(rsp_s);
  assign tgt_s       = word_align(redirect_pc);

  // PCs, outstanding count and stale-response drop count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      outst_r    <= '0;
      drop_r     <= '0;
    end else begin
      outst_r <= outst_nxt_s;
      if (redirect_vld) begin
        fetch_pc_r <= tgt_s;
        resp_pc_r  <= tgt_s;
        drop_r     <= outst_nxt_s;
      end else begin
        if (gnt_s)     fetch_pc_r <= fetch_pc_r + PC_INC;
        if (push_s)    resp_pc_r  <= resp_pc_r + PC_INC;
        if (discard_s) drop_r     <= drop_r - CW'(1'b1);
      end
    end
  end

  assign push_entry_s = '{instr: imem.imem_rdata, pc: resp_pc_r};

  ifetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_vld),
    .wdata (push_entry_s),
    .rdata (head_s),
    .count (count_s),
    .empty (empty_s)
  );

  assign imem.imem_req  = req_s;
  assign imem.imem_addr = fetch_pc_r;
  assign instr_vld      = !empty_s;
  assign instr          = head_s.instr;
  assign instr_pc       = head_s.pc;

`ifdef IFETCH_PERF_CNT_EN
  // performance counters, free-running modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
      perf_dropped <= 32'd0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop_s);
      perf_stall   <= perf_stall + 32'(issue_en_s & !instr_vld);
      perf_dropped <= perf_dropped + 32'(discard_s);
    end
  end
`endif

  ifetch_unit_chk u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .gnt      (gnt_s),
    .rvalid   (imem.imem_rvalid),
    .no_outst (outst_r == '0)
  );

endmodule
